read_ctrl: RTL and testbench
============================

# read_ctrl

Read-side sequencer for the two-slot ping-pong buffer memory. It watches the per-slot valid flags from the write controller and reads filled slots in strict alternating order (slot 0, 1, 0, ...). Each read data word is presented on a valid/ready output stream. After the downstream accepts a word, the block pulses the matching `r_done` bit so the write controller can free that slot. It sits between the buffer memory's read port and the downstream consumer, mirroring the write controller on the fill side.

## Interface
- `DATA_W`, 8, width of memory word and output data
- `RD_LAT`, 1, memory read latency in cycles (legal range 1..7); `r_data` is valid `RD_LAT` cycles after the cycle `r_en` is high
- `clk` in 1: system clock, rising edge
- `n_rst` in 1: reset, asynchronous, active-low
- `status_vld` in 2: bit i = slot i holds unread data (driven by write controller)
- `r_done` out 2: one-cycle one-hot pulse; bit i = slot i consumed
- `r_addr` out 1: memory read address (slot index)
- `r_en` out 1: memory read enable, one-cycle pulse per read
- `r_data` in DATA_W: memory read data
- `dout` out DATA_W: output data, registered
- `dout_vld` out 1: `dout` valid
- `dout_rdy` in 1: downstream accepts `dout`
- `empty` out 1: combinational, `status_vld == 2'b00`
- `busy` out 1: registered, high whenever state != IDLE

## Operation
- Reset values: state IDLE, rd_ptr 0, `r_done` 00, `r_addr` 0, `r_en` 0, `dout` 0, `dout_vld` 0, `busy` 0, latency counter 0.
- rd_ptr: 1-bit slot pointer. It toggles only on exit from DONE (wrap 1 -> 0).
- FSM states:
  - IDLE: if `status_vld[rd_ptr]`, go to REQ. Otherwise stay. The other slot's flag is ignored, which enforces order.
  - REQ (1 cycle): `r_en`=1, `r_addr`=rd_ptr. Counter loads `RD_LAT`-1. Go to WAIT.
  - WAIT (`RD_LAT` cycles): `r_addr` holds rd_ptr, `r_en`=0. Counter decrements each cycle. In the cycle the counter reads 0, `dout` captures `r_data` at the closing edge and the FSM goes to OUT.
  - OUT: `dout_vld`=1 and `dout` stable until the handshake. On an edge with `dout_vld`&&`dout_rdy`, go to DONE.
  - DONE (1 cycle): `r_done[rd_ptr]`=1 and `dout_vld`=0. On exit, rd_ptr toggles and the FSM goes to IDLE.
- `status_vld` is sampled only in IDLE. A deassertion of `status_vld[rd_ptr]` during REQ/WAIT/OUT does not abort the read; the transaction completes.
- `status_vld[old slot]` may still be high in the cycle after DONE. This does not cause a re-read, because rd_ptr has already moved.
- Both flags set: slot rd_ptr is served first, then the other slot. There are no back-to-back reads without passing through IDLE.
- `n_rst` asserted mid-transaction: all outputs return to reset values immediately. A pending word is discarded and no `r_done` is issued.

## Timing
- Let cycle 0 be the IDLE cycle in which `status_vld[rd_ptr]`=1 is sampled.
- `r_en` is high in cycle 1.
- `dout_vld` rises in cycle 2+`RD_LAT`.
- With `dout_rdy` held high, the accept edge ends cycle 2+`RD_LAT`, `r_done` is high in cycle 3+`RD_LAT`, and IDLE is reached in cycle 4+`RD_LAT`.
- Minimum slot period is 4+`RD_LAT` cycles (5 at default).
- Backpressure: each cycle of `dout_rdy`=0 in OUT adds exactly one cycle. `dout` and `dout_vld` must not change while stalled.
- `r_done` is never high in two consecutive cycles and never has both bits set.
- `busy` is high from cycle 1 through the DONE cycle inclusive.

## Test plan
- Single read, default params, memory model holds slot0=0xEF and slot1=0x98. Set `status_vld`=01 with `dout_rdy`=1 -> `r_en`=1 and `r_addr`=0 in cycle 1; `dout`=0xEF and `dout_vld`=1 in cycle 3; `r_done`=01 in cycle 4; `busy` low in cycle 5.
- Both slots full (`status_vld`=11), `dout_rdy`=1 -> outputs 0xEF then 0x98; `r_done`=01 then 10; consecutive `r_en` pulses 5 cycles apart.
- Order enforcement: after slot 0 is consumed (rd_ptr=1), set `status_vld`=01 only -> no `r_en` for 10 cycles. Then set `status_vld`=11 -> slot 1 is read (0x98).
- Backpressure: hold `dout_rdy`=0 for 4 cycles after `dout_vld` rises -> `dout`=0xEF stable throughout and `r_done` appears exactly 4 cycles later than in the first test.
- `RD_LAT`=3: `status_vld`=10 at rd_ptr=1 -> `r_en` in cycle 1, `dout_vld` in cycle 5, `dout`=0x98.
- Reset mid-OUT: pull `n_rst` low while `dout_vld`=1 -> `dout_vld`, `r_done`, `busy` and `dout` go to 0 immediately. After release with `status_vld`=01, the next read uses `r_addr`=0.

Source files
------------

// File: rtl/read_ctrl.sv
// -----------------------------------------------------------------------------
// read_ctrl
//
// Read-side sequencer for the two-slot ping-pong buffer. Slots are read in
// strict alternation (0, 1, 0, ...): only the flag of the slot the read
// pointer currently targets is looked at, so a filled "other" slot never
// jumps the queue. Each word fetched from the buffer memory is held on a
// valid/ready output until the consumer takes it, after which a one-cycle
// r_done pulse tells the write controller that slot can be refilled.
//
// Ports
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   status_vld  per-slot "holds unread data" flags from the write controller
//   r_done      one-cycle one-hot pulse, bit i = slot i consumed
//   r_addr      memory read address (slot index)
//   r_en        memory read enable, one-cycle pulse per read
//   r_data      memory read data, valid RD_LAT cycles after r_en
//   dout        registered output word
//   dout_vld    dout valid
//   dout_rdy    downstream accepts dout
//   empty       both slot flags clear (combinational)
//   busy        registered, high whenever a read transaction is in flight
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for status_vld[rd_ptr]
//   REQ     | r_en pulse, latency counter loaded with RD_LAT-1
//   WAIT    | counting down memory latency; capture r_data when count is 0
//   OUT     | dout_vld high, holding dout until dout_rdy
//   DONE    | r_done pulse for the slot just consumed, rd_ptr toggles on exit
// -----------------------------------------------------------------------------
module read_ctrl #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [1:0]        status_vld,
    output logic [1:0]        r_done,
    output logic              r_addr,
    output logic              r_en,
    input  logic [DATA_W-1:0] r_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              empty,
    output logic              busy
);

    // RD_LAT is limited to 1..7, so a 3-bit down-counter covers RD_LAT-1.
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rd_ptr;
    logic        rd_ptr_nxt;
    logic [2:0]  lat_cnt;
    logic [2:0]  lat_cnt_nxt;
    logic        capture;

    // -------------------------------------------------------------------------
    // State, pointer and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            rd_ptr  <= 1'b0;
            lat_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            rd_ptr  <= rd_ptr_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        rd_ptr_nxt  = rd_ptr;
        lat_cnt_nxt = lat_cnt;
        capture     = 1'b0;
        r_en        = 1'b0;
        r_done      = 2'b00;
        dout_vld    = 1'b0;

        case (state)
            ST_IDLE: begin
                // Only the targeted slot counts; this is what enforces order.
                if (status_vld[rd_ptr]) begin
                    state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                r_en        = 1'b1;
                lat_cnt_nxt = LAT_LOAD;
                state_nxt   = ST_WAIT;
            end

            ST_WAIT: begin
                if (lat_cnt == 3'd0) begin
                    capture   = 1'b1;
                    state_nxt = ST_OUT;
                end else begin
                    lat_cnt_nxt = lat_cnt - 3'd1;
                end
            end

            ST_OUT: begin
                dout_vld = 1'b1;
                if (dout_rdy) begin
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                r_done     = rd_ptr ? 2'b10 : 2'b01;
                rd_ptr_nxt = ~rd_ptr;
                state_nxt  = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output data register: loads only on the last latency cycle, so it stays
    // frozen throughout OUT regardless of backpressure.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dout <= '0;
        end else if (capture) begin
            dout <= r_data;
        end
    end

    // busy tracks the state the FSM is entering, so it lines up with the
    // state register without an extra cycle of lag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
        end
    end

    assign r_addr = rd_ptr;
    assign empty  = (status_vld == 2'b00);

endmodule

// File: tb/tb_read_ctrl.sv
module tb_read_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;

    logic [1:0] status_a, r_done_a;
    logic       r_addr_a, r_en_a, dout_vld_a, dout_rdy_a, empty_a, busy_a;
    logic [7:0] r_data_a, dout_a;

    logic [1:0] status_b, r_done_b;
    logic       r_addr_b, r_en_b, dout_vld_b, dout_rdy_b, empty_b, busy_b;
    logic [7:0] r_data_b, dout_b;
    logic [7:0] pipe_b1, pipe_b2;

    int n_cmp = 0;
    int n_err = 0;
    logic saw;

    always #5 clk = ~clk;

    read_ctrl #(.DATA_W(8), .RD_LAT(1)) dut_a (
        .clk(clk), .n_rst(n_rst), .status_vld(status_a), .r_done(r_done_a),
        .r_addr(r_addr_a), .r_en(r_en_a), .r_data(r_data_a), .dout(dout_a),
        .dout_vld(dout_vld_a), .dout_rdy(dout_rdy_a), .empty(empty_a), .busy(busy_a)
    );

    read_ctrl #(.DATA_W(8), .RD_LAT(3)) dut_b (
        .clk(clk), .n_rst(n_rst), .status_vld(status_b), .r_done(r_done_b),
        .r_addr(r_addr_b), .r_en(r_en_b), .r_data(r_data_b), .dout(dout_b),
        .dout_vld(dout_vld_b), .dout_rdy(dout_rdy_b), .empty(empty_b), .busy(busy_b)
    );

    // Memory: slot0 = 0xEF, slot1 = 0x98. Data is only correct in the one cycle
    // it is promised; otherwise 0x5A, so a mistimed capture shows up.
    function automatic logic [7:0] mem_rd(input logic a);
        return a ? 8'h98 : 8'hEF;
    endfunction

    always @(posedge clk) begin
        r_data_a <= r_en_a ? mem_rd(r_addr_a) : 8'h5A;
        pipe_b1  <= r_en_b ? mem_rd(r_addr_b) : 8'h5A;
        pipe_b2  <= pipe_b1;
        r_data_b <= pipe_b2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_rst      = 1'b0;
        status_a   = 2'b00;
        status_b   = 2'b00;
        dout_rdy_a = 1'b0;
        dout_rdy_b = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_dout",  32'(dout_a), 32'h00);
        chk("rst_vld",   32'(dout_vld_a), 32'h0);
        chk("rst_ren",   32'(r_en_a), 32'h0);
        chk("rst_done",  32'(r_done_a), 32'h0);
        chk("rst_busy",  32'(busy_a), 32'h0);
        chk("rst_addr",  32'(r_addr_a), 32'h0);
        chk("rst_empty", 32'(empty_a), 32'h1);
        chk("rst_busy_b",  32'(busy_b), 32'h0);
        chk("rst_empty_b", 32'(empty_b), 32'h1);
        n_rst = 1'b1;
        step();

        // Single read, slot 0
        status_a = 2'b01; dout_rdy_a = 1'b1;
        #1 chk("t1_empty", 32'(empty_a), 32'h0);
        step(); // c1
        chk("t1_ren_c1",  32'(r_en_a), 32'h1);
        chk("t1_addr_c1", 32'(r_addr_a), 32'h0);
        chk("t1_busy_c1", 32'(busy_a), 32'h1);
        step(); // c2
        chk("t1_ren_c2", 32'(r_en_a), 32'h0);
        chk("t1_vld_c2", 32'(dout_vld_a), 32'h0);
        step(); // c3
        chk("t1_dout_c3", 32'(dout_a), 32'hEF);
        chk("t1_vld_c3",  32'(dout_vld_a), 32'h1);
        chk("t1_done_c3", 32'(r_done_a), 32'h0);
        step(); // c4
        chk("t1_done_c4", 32'(r_done_a), 32'h1);
        chk("t1_vld_c4",  32'(dout_vld_a), 32'h0);
        chk("t1_busy_c4", 32'(busy_a), 32'h1);
        status_a = 2'b00;
        step(); // c5
        chk("t1_busy_c5", 32'(busy_a), 32'h0);
        chk("t1_done_c5", 32'(r_done_a), 32'h0);

        // Order enforcement: rd_ptr is 1, only slot 0 flagged
        status_a = 2'b01;
        saw = 1'b0;
        repeat (10) begin
            step();
            saw = saw | r_en_a | busy_a;
        end
        chk("ord_no_read", 32'(saw), 32'h0);
        status_a = 2'b11;
        step(); // c1
        chk("ord_ren_c1",  32'(r_en_a), 32'h1);
        chk("ord_addr_c1", 32'(r_addr_a), 32'h1);
        step();
        step(); // c3
        chk("ord_dout_c3", 32'(dout_a), 32'h98);
        chk("ord_vld_c3",  32'(dout_vld_a), 32'h1);
        step(); // c4
        chk("ord_done_c4", 32'(r_done_a), 32'h2);
        status_a = 2'b00;
        step(); // c5
        chk("ord_busy_c5", 32'(busy_a), 32'h0);

        // Both slots full, rd_ptr 0: EF then 98, r_en 5 cycles apart
        status_a = 2'b11;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk($sformatf("both_ren_c%0d", c), 32'(r_en_a), 32'((c == 1) || (c == 6)));
            chk($sformatf("both_vld_c%0d", c), 32'(dout_vld_a), 32'((c == 3) || (c == 8)));
            chk($sformatf("both_done_c%0d", c), 32'(r_done_a),
                (c == 4) ? 32'h1 : ((c == 9) ? 32'h2 : 32'h0));
            if (c == 1) chk("both_addr_c1", 32'(r_addr_a), 32'h0);
            if (c == 6) chk("both_addr_c6", 32'(r_addr_a), 32'h1);
            if (c == 3) chk("both_dout_c3", 32'(dout_a), 32'hEF);
            if (c == 8) chk("both_dout_c8", 32'(dout_a), 32'h98);
            if (c == 4) status_a = 2'b10;
            if (c == 9) status_a = 2'b00;
        end
        chk("both_busy_end", 32'(busy_a), 32'h0);

        // Backpressure: dout_rdy low for 4 cycles of dout_vld
        status_a = 2'b01;
        step(); // c1
        chk("bp_ren_c1", 32'(r_en_a), 32'h1);
        step(); // c2
        dout_rdy_a = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            step();
            chk($sformatf("bp_vld_c%0d", c),  32'(dout_vld_a), 32'h1);
            chk($sformatf("bp_dout_c%0d", c), 32'(dout_a), 32'hEF);
            chk($sformatf("bp_done_c%0d", c), 32'(r_done_a), 32'h0);
        end
        step(); // c7
        chk("bp_vld_c7",  32'(dout_vld_a), 32'h1);
        chk("bp_dout_c7", 32'(dout_a), 32'hEF);
        chk("bp_done_c7", 32'(r_done_a), 32'h0);
        dout_rdy_a = 1'b1;
        step(); // c8
        chk("bp_done_c8", 32'(r_done_a), 32'h1);
        chk("bp_vld_c8",  32'(dout_vld_a), 32'h0);
        status_a = 2'b00;
        step(); // c9
        chk("bp_busy_c9", 32'(busy_a), 32'h0);

        // Reset mid-OUT (rd_ptr 1)
        status_a = 2'b10; dout_rdy_a = 1'b0;
        step(); // c1
        chk("rm_ren_c1",  32'(r_en_a), 32'h1);
        chk("rm_addr_c1", 32'(r_addr_a), 32'h1);
        step();
        step(); // c3
        chk("rm_vld_c3",  32'(dout_vld_a), 32'h1);
        chk("rm_dout_c3", 32'(dout_a), 32'h98);
        step(); // c4, still stalled
        n_rst = 1'b0;
        #1;
        chk("rm_vld",  32'(dout_vld_a), 32'h0);
        chk("rm_dout", 32'(dout_a), 32'h00);
        chk("rm_busy", 32'(busy_a), 32'h0);
        chk("rm_done", 32'(r_done_a), 32'h0);
        chk("rm_addr", 32'(r_addr_a), 32'h0);
        step();
        step();
        status_a = 2'b01; dout_rdy_a = 1'b1; n_rst = 1'b1;
        saw = 1'b0;
        step(); // c1
        chk("rr_ren_c1",  32'(r_en_a), 32'h1);
        chk("rr_addr_c1", 32'(r_addr_a), 32'h0);
        saw = saw | (r_done_a != 2'b00);
        step();
        saw = saw | (r_done_a != 2'b00);
        step(); // c3
        saw = saw | (r_done_a != 2'b00);
        chk("rr_dout_c3", 32'(dout_a), 32'hEF);
        chk("rr_no_stale_done", 32'(saw), 32'h0);
        step(); // c4
        chk("rr_done_c4", 32'(r_done_a), 32'h1);
        status_a = 2'b00;
        step();

        // RD_LAT = 3: slot 0 first to move rd_ptr, then slot 1
        status_b = 2'b01; dout_rdy_b = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("l3a_ren_c%0d", c), 32'(r_en_b), 32'(c == 1));
            chk($sformatf("l3a_vld_c%0d", c), 32'(dout_vld_b), 32'(c == 5));
            chk($sformatf("l3a_done_c%0d", c), 32'(r_done_b), (c == 6) ? 32'h1 : 32'h0);
            if (c == 5) chk("l3a_dout_c5", 32'(dout_b), 32'hEF);
            if (c == 6) status_b = 2'b00;
        end
        status_b = 2'b10;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("l3b_ren_c%0d", c), 32'(r_en_b), 32'(c == 1));
            chk($sformatf("l3b_vld_c%0d", c), 32'(dout_vld_b), 32'(c == 5));
            chk($sformatf("l3b_done_c%0d", c), 32'(r_done_b), (c == 6) ? 32'h2 : 32'h0);
            if (c == 1) chk("l3b_addr_c1", 32'(r_addr_b), 32'h1);
            if (c == 5) chk("l3b_dout_c5", 32'(dout_b), 32'h98);
            if (c == 6) status_b = 2'b00;
        end
        chk("l3b_busy_end", 32'(busy_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
